// File: rtl/usbh_tx_crc_append.sv
// usbh_tx_crc_append: registered payload pass-through that appends the
// inverted USB CRC16 (low byte first) to every data packet.
module usbh_tx_crc_append (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       abort_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  input  logic       in_zlp_i,
  output logic       in_accept_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  input  logic       out_accept_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    CRC_LO = 2'd1,
    CRC_HI = 2'd2
  } state_t;

  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic        ov_q, ov_d;
  logic        ol_q, ol_d;
  logic [7:0]  od_q, od_d;
  logic        slot;

  // Reflected x^16+x^15+x^2+1, one byte, LSB first.
  function automatic logic [15:0] crc16_upd(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign slot        = !ov_q || out_accept_i;
  assign in_accept_o = slot && (state_q == DATA) && !abort_i;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_last_o  = ol_q;
  assign busy_o      = (state_q != DATA) || ov_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    od_d    = od_q;
    if (ov_q && out_accept_i) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end
    if (abort_i) begin
      state_d = DATA;
      crc_d   = CRC_SEED;
      ov_d    = 1'b0;
      ol_d    = 1'b0;
    end else begin
      unique case (state_q)
        DATA: begin
          if (in_valid_i && slot) begin
            if (in_last_i && in_zlp_i) begin
              state_d = CRC_LO;
            end else begin
              od_d  = in_data_i;
              ov_d  = 1'b1;
              ol_d  = 1'b0;
              crc_d = crc16_upd(crc_q, in_data_i);
              if (in_last_i) state_d = CRC_LO;
            end
          end
        end
        CRC_LO: begin
          if (slot) begin
            od_d    = ~crc_q[7:0];
            ov_d    = 1'b1;
            ol_d    = 1'b0;
            state_d = CRC_HI;
          end
        end
        CRC_HI: begin
          if (slot) begin
            od_d    = ~crc_q[15:8];
            ov_d    = 1'b1;
            ol_d    = 1'b1;
            crc_d   = CRC_SEED;
            state_d = DATA;
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= DATA;
      crc_q   <= CRC_SEED;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      od_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      od_q    <= od_d;
    end
  end

endmodule

// File: tb/tb_usbh_tx_crc_append.sv
// tb_usbh_tx_crc_append: random and directed packets checked against
// a bit-serial CRC16 reference and a byte-sequence scoreboard.
module tb_usbh_tx_crc_append;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       in_last_i = 1'b0;
  logic       in_zlp_i = 1'b0;
  logic       in_accept_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       out_accept_i = 1'b0;
  logic       busy_o;

  usbh_tx_crc_append dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_zlp_i    (in_zlp_i),
    .in_accept_o (in_accept_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_accept_i(out_accept_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       zlp;
  } src_t;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } out_t;

  src_t       src_q[$];
  out_t       exp_q[$];
  out_t       got_q[$];
  int         got_cyc[$];
  logic [7:0] pay_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC over the whole message as one LSB-first bit stream.
  function automatic logic [15:0] crc_bits(input logic [7:0] b[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic add_pkt(input bit junk_zlp);
    logic [15:0] c;
    src_t        s;
    if (pay_q.size() == 0) begin
      s.d    = 8'($urandom);
      s.last = 1'b1;
      s.zlp  = 1'b1;
      src_q.push_back(s);
    end else begin
      foreach (pay_q[i]) begin
        s.d    = pay_q[i];
        s.last = (i == pay_q.size() - 1);
        s.zlp  = (!s.last && junk_zlp) ? 1'($urandom) : 1'b0;
        src_q.push_back(s);
        exp_q.push_back('{pay_q[i], 1'b0});
      end
    end
    c = crc_bits(pay_q);
    exp_q.push_back('{~c[7:0], 1'b0});
    exp_q.push_back('{~c[15:8], 1'b1});
    pay_q.delete();
  endtask

  // Called from the low clock phase; returns at a negedge.
  task automatic run(input int acc_mode, input int gaps, input int budget);
    int         cyc;
    bit         prev_stall;
    bit         tog;
    logic [7:0] pd;
    logic       pl;
    logic [7:0] pkt[$];
    int         n;
    cyc = 0;
    prev_stall = 1'b0;
    tog = 1'b1;
    pd = 8'h00;
    pl = 1'b0;
    got_q.delete();
    got_cyc.delete();
    while ((src_q.size() > 0 || got_q.size() < exp_q.size())
           && cyc < budget) begin
      if (src_q.size() > 0 && !(gaps != 0 && $urandom_range(0, 3) == 0)) begin
        in_valid_i = 1'b1;
        in_data_i  = src_q[0].d;
        in_last_i  = src_q[0].last;
        in_zlp_i   = src_q[0].zlp;
      end else begin
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
        in_last_i  = 1'($urandom);
        in_zlp_i   = 1'($urandom);
      end
      case (acc_mode)
        0:       out_accept_i = 1'b1;
        1:       out_accept_i = tog;
        default: out_accept_i = 1'($urandom);
      endcase
      tog = ~tog;
      #1;
      if (prev_stall) begin
        chk("hold_data", out_data_o, pd);
        chk("hold_last", out_last_o, pl);
      end
      if (out_valid_o && !out_accept_i) chk("accept_full", in_accept_o, 0);
      if (in_valid_i && in_accept_o) void'(src_q.pop_front());
      if (out_valid_o && out_accept_i) begin
        got_q.push_back('{out_data_o, out_last_o});
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid_o && !out_accept_i;
      pd = out_data_o;
      pl = out_last_o;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid_i   = 1'b0;
    in_last_i    = 1'b0;
    in_zlp_i     = 1'b0;
    out_accept_i = 1'b0;
    chk("timeout", 32'(cyc < budget), 1);
    chk("n_out", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("out_data", got_q[i].d, exp_q[i].d);
      chk("out_last", got_q[i].last, exp_q[i].last);
    end
    foreach (got_q[i]) begin
      pkt.push_back(got_q[i].d);
      if (got_q[i].last) begin
        chk("residual", crc_bits(pkt), 16'hB001);
        pkt.delete();
      end
    end
    src_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_accept", in_accept_o, 1);
    chk("idle_busy", busy_o, 0);
    @(negedge clk);

    add_pkt(0);
    run(0, 0, 50);
    chk("zlp_lo", got_q[0].d, 8'h00);
    chk("zlp_hi", got_q[1].d, 8'h00);
    chk("zlp_busy_after", busy_o, 0);

    pay_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    add_pkt(0);
    run(0, 0, 50);
    chk("pkt4_span", got_cyc[5] - got_cyc[0], 5);

    pay_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    add_pkt(0);
    run(1, 0, 80);

    pay_q = '{8'hA5};
    add_pkt(0);
    pay_q = '{8'h3C};
    add_pkt(0);
    run(0, 0, 50);
    chk("b2b_span", got_cyc[5] - got_cyc[0], 5);

    abort_i      = 1'b1;
    in_valid_i   = 1'b1;
    in_data_i    = 8'h77;
    out_accept_i = 1'b1;
    #1;
    chk("abort_accept", in_accept_o, 0);
    @(negedge clk);
    abort_i      = 1'b0;
    in_data_i    = 8'h5A;
    in_last_i    = 1'b1;
    out_accept_i = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    #1;
    chk("pre_abort_valid", out_valid_o, 1);
    chk("pre_abort_busy", busy_o, 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    chk("abort_valid", out_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    @(negedge clk);
    add_pkt(0);
    run(0, 0, 50);
    chk("abort_zlp_lo", got_q[0].d, 8'h00);
    chk("abort_zlp_hi", got_q[1].d, 8'h00);

    in_valid_i   = 1'b1;
    in_data_i    = 8'hC3;
    out_accept_i = 1'b0;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_data", out_data_o, 0);
    chk("arst_last", out_last_o, 0);
    chk("arst_busy", busy_o, 0);
    in_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    pay_q = '{8'($urandom)};
    add_pkt(0);
    run(0, 0, 50);

    for (int p = 0; p < 8; p++) begin
      for (int i = $urandom_range(0, 8); i > 0; i--) begin
        pay_q.push_back(8'($urandom));
      end
      add_pkt(1);
    end
    run(2, 1, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usbh_tx_crc_append.md
Name: usbh_tx_crc_append

Overview:
- Transmit-path stage between the packet byte source (DATA PID already emitted upstream) and the bit-level serializer.
- Passes data-packet payload bytes through a one-deep registered output stage while accumulating the USB CRC16 byte by byte.
- On the last payload byte, appends the two inverted CRC bytes, low byte first, and marks the final CRC byte as end of packet.
- Supports zero-length data packets; the output is then the CRC only.

Parameters:
- none

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-low
- abort_i  input  1  synchronous flush; return to idle, drop any held byte
- in_valid_i  input  1  payload byte valid
- in_data_i  input  8  payload byte, bit 0 transmitted first
- in_last_i  input  1  qualifies in_data_i as the final payload byte
- in_zlp_i  input  1  with in_valid_i & in_last_i: zero-length packet; in_data_i ignored
- in_accept_o  output  1  upstream byte consumed this cycle when in_valid_i & in_accept_o
- out_valid_o  output  1  output byte valid
- out_data_o  output  8  output byte
- out_last_o  output  1  final byte of packet (CRC high byte)
- out_accept_i  input  1  downstream consumed output byte this cycle
- busy_o  output  1  packet in progress (state != IDLE or out_valid_o)

Behaviour:
- Reset (rst_i low, asynchronous):
  - out_valid_o=0, out_data_o=0x00, out_last_o=0, busy_o=0.
  - state=IDLE, crc register=0xFFFF.
- CRC:
  - Polynomial x^16+x^15+x^2+1, reflected, byte-wise, LSB first.
  - Seed 0xFFFF at the start of each packet.
  - Update uses the team's existing combinational byte update: crc_next=f(crc, byte).
  - Transmitted value is ~crc: low byte ~crc[7:0] first, then ~crc[15:8].
- Output register:
  - Load is permitted when !out_valid_o || out_accept_i (the "slot" is free).
  - in_accept_o = slot && state==DATA.
  - Latency from input acceptance to out_valid_o is 1 cycle.
  - Back-to-back throughput is 1 byte/cycle.
- States:
  - IDLE/DATA is one state, called DATA. It accepts bytes.
    - On accept of a non-last byte: out_data_o<=in_data_i, out_valid_o<=1, out_last_o<=0, crc<=f(crc,in_data_i).
    - On accept with in_last_i & !in_zlp_i: same as above, then go to CRC_LO.
    - On accept with in_last_i & in_zlp_i: no data byte is loaded, crc remains 0xFFFF, go to CRC_LO.
  - CRC_LO: in_accept_o=0. When the slot is free: out_data_o<=~crc[7:0], out_valid_o<=1, out_last_o<=0, go to CRC_HI.
  - CRC_HI: when the slot is free: out_data_o<=~crc[15:8], out_valid_o<=1, out_last_o<=1, crc<=0xFFFF, go to DATA.
- Outside any load cycle: out_accept_i & out_valid_o clears out_valid_o and out_last_o. out_data_o holds its value.
- Output stability: while out_valid_o & !out_accept_i, out_data_o and out_last_o are stable.
- Next packet:
  - A new packet may begin in DATA on the cycle after the CRC high byte is loaded.
  - Its first byte loads in the same cycle the CRC high byte is accepted.
- in_zlp_i without in_last_i is ignored: the byte is treated as a normal data byte.
- abort_i (highest priority, synchronous):
  - Sets state=DATA, crc=0xFFFF, out_valid_o=0, out_last_o=0.
  - in_accept_o=0 in the abort cycle.
- in_last_i or in_zlp_i sampled without in_valid_i has no effect.
- Bytes arriving while in CRC_LO/CRC_HI are stalled, never dropped.

Test Plan:
- Reset released, idle: out_valid_o=0, busy_o=0, in_accept_o=1. ZLP (in_valid_i, in_last_i, in_zlp_i for one cycle) with out_accept_i=1 -> output 0x00 (last=0), then 0x00 (last=1). Total 2 output bytes, busy_o then drops.
- 4-byte packet 00 01 02 03 streamed with out_accept_i=1 -> 6 output bytes in 6 consecutive cycles. First 4 bytes echo the payload, last=1 only on byte 6. Feeding all 6 bytes through the reference CRC model from 0xFFFF gives residual 0xB001.
- Same packet with out_accept_i toggling 1010... -> identical 6-byte sequence. in_accept_o is never high while the slot is full. out_data_o stays stable during every stall.
- Two back-to-back 1-byte packets 0xA5 then 0x3C -> 3+3 bytes with no idle cycle between packets. Second packet's CRC is computed from seed 0xFFFF; each packet's residual is 0xB001.
- abort_i asserted while in CRC_LO with a byte held -> next cycle out_valid_o=0, busy_o=0. A following ZLP yields 00 00.
- rst_i driven low asynchronously mid-packet, between clock edges -> outputs return to reset values immediately. After release, a 1-byte packet is processed correctly with residual 0xB001.
